// File: rtl/trace_capture_if.sv
// Sensor-sample and UART byte-stream signals of the trace recorder.
// The slave side is the recorder and the master side is whoever drives it.
interface trace_capture_if #(
  parameter int NUM_CH = 1
);
  logic [8*NUM_CH-1:0] sample_i;
  logic                arm_i;
  logic                trig_i;
  logic                done_i;
  logic                tx_dv_o;
  logic [7:0]          tx_byte_o;
  logic                tx_done_i;
  logic                busy_o;
  logic                trace_done_o;

  modport master (
    output sample_i, arm_i, trig_i, done_i, tx_done_i,
    input  tx_dv_o, tx_byte_o, busy_o, trace_done_o
  );

  modport slave (
    input  sample_i, arm_i, trig_i, done_i, tx_done_i,
    output tx_dv_o, tx_byte_o, busy_o, trace_done_o
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Multi-channel circular trace recorder with pre-trigger window and byte-serial UART readout.
// Define TRACE_HDR_EN to prefix each trace with a 4-byte header (A5, NUM_CH, first done index).
module trace_capture_ctrl #(
  parameter int         NUM_CH     = 1,
  parameter int         DEPTH      = 1024,
  parameter int         PRE_TRIG   = 0,
  parameter logic [7:0] MARK_DONE  = 8'hFF,
  parameter int         GAP_CYCLES = 4096
) (
  input logic            clk,
  input logic            rst,
  trace_capture_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DATA_BYTES = NUM_CH * DEPTH;
  localparam int BC_W  = $clog2(DATA_BYTES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
`ifdef TRACE_HDR_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam int LAST_BYTE = HDR + DATA_BYTES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_SEND, S_SEND_WAIT, S_GAP
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] wp_q, pf_q, sp_q, cnt_q;
  logic [BC_W-1:0]  bc_q;
  logic [GAP_W-1:0] gap_q;
  logic             rd_ph_q;
  logic             tx_dv_q, trace_done_q;
  logic [7:0]       tx_byte_q;
  logic [7:0]       rd_q;
`ifdef TRACE_HDR_EN
  logic [15:0]      fd_q;
`endif

  logic [7:0] mem [NUM_CH][DEPTH];

  logic             trig_ok, mem_we, mark;
  logic [BC_W-1:0]  data_n;
  logic [PTR_W-1:0] rd_idx, rd_addr;
  logic [CH_W-1:0]  rd_ch;
  logic [7:0]       tx_next;

  assign trig_ok = (state_q == S_ARMED) && bus.trig_i && (pf_q == PTR_W'(PRE_TRIG));
  assign mem_we  = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  // Pre-trigger cycles never carry the done mark; the trigger cycle itself does.
  assign mark    = bus.done_i && ((state_q == S_CAPTURE) || trig_ok);

  // DEPTH is a power of two, so the data byte number splits into channel and index.
  assign data_n  = bc_q - BC_W'(HDR);
  assign rd_idx  = PTR_W'(data_n);
  assign rd_ch   = CH_W'(data_n >> PTR_W);
  assign rd_addr = sp_q + rd_idx;

  always_comb begin
    tx_next = rd_q;
`ifdef TRACE_HDR_EN
    case (bc_q)
      BC_W'(0): tx_next = 8'hA5;
      BC_W'(1): tx_next = 8'(NUM_CH);
      BC_W'(2): tx_next = fd_q[15:8];
      BC_W'(3): tx_next = fd_q[7:0];
      default:  tx_next = rd_q;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[c][wp_q] <= mark ? MARK_DONE : bus.sample_i[8*c +: 8];
      end
    end
    rd_q <= mem[rd_ch][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wp_q         <= '0;
      pf_q         <= '0;
      sp_q         <= '0;
      cnt_q        <= '0;
      bc_q         <= '0;
      gap_q        <= '0;
      rd_ph_q      <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      trace_done_q <= 1'b0;
`ifdef TRACE_HDR_EN
      fd_q         <= 16'hFFFF;
`endif
    end else begin
      tx_dv_q      <= 1'b0;
      trace_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.arm_i) begin
            state_q <= S_ARMED;
            wp_q    <= '0;
            pf_q    <= '0;
`ifdef TRACE_HDR_EN
            fd_q    <= 16'hFFFF;
`endif
          end
        end
        S_ARMED: begin
          wp_q <= wp_q + PTR_W'(1);
          if (pf_q != PTR_W'(PRE_TRIG)) pf_q <= pf_q + PTR_W'(1);
          if (trig_ok) begin
            sp_q    <= wp_q - PTR_W'(PRE_TRIG);
            cnt_q   <= PTR_W'(DEPTH - PRE_TRIG - 1);
            bc_q    <= '0;
            rd_ph_q <= 1'b0;
            state_q <= (DEPTH - PRE_TRIG - 1 == 0) ? S_SEND : S_CAPTURE;
`ifdef TRACE_HDR_EN
            if (mark) fd_q <= 16'(PRE_TRIG);
`endif
          end
        end
        S_CAPTURE: begin
          wp_q  <= wp_q + PTR_W'(1);
          cnt_q <= cnt_q - PTR_W'(1);
`ifdef TRACE_HDR_EN
          if (mark && (fd_q == 16'hFFFF)) fd_q <= 16'(DEPTH) - 16'(cnt_q);
`endif
          if (cnt_q == PTR_W'(1)) state_q <= S_SEND;
        end
        S_SEND: begin
          // First cycle presents the read address, second cycle launches the byte.
          if (!rd_ph_q) begin
            rd_ph_q <= 1'b1;
          end else begin
            rd_ph_q   <= 1'b0;
            tx_byte_q <= tx_next;
            tx_dv_q   <= 1'b1;
            state_q   <= S_SEND_WAIT;
          end
        end
        S_SEND_WAIT: begin
          if (bus.tx_done_i) begin
            if (bc_q == BC_W'(LAST_BYTE)) begin
              state_q      <= S_GAP;
              gap_q        <= '0;
              trace_done_q <= 1'b1;
            end else begin
              bc_q    <= bc_q + BC_W'(1);
              state_q <= S_SEND;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_q <= S_IDLE;
          else gap_q <= gap_q + GAP_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_dv_o      = tx_dv_q;
  assign bus.tx_byte_o    = tx_byte_q;
  assign bus.trace_done_o = trace_done_q;
  assign bus.busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed-plus-random bench for trace_capture_ctrl with a trace-window reference model.
// Follows TRACE_HDR_EN when the bundle is built with that macro defined.
module tb_trace_capture_ctrl;

  localparam int         NUM_CH     = 3;
  localparam int         DEPTH      = 16;
  localparam int         PRE_TRIG   = 4;
  localparam int         GAP_CYCLES = 8;
  localparam int         MAXN       = 64;
  localparam logic [7:0] MARK       = 8'hFF;
`ifdef TRACE_HDR_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = HDR + NUM_CH * DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trace_capture_if #(.NUM_CH(NUM_CH)) bus ();

  trace_capture_ctrl #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG),
    .MARK_DONE(MARK), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] samp [MAXN][NUM_CH];
  logic       tg   [MAXN];
  logic       dn   [MAXN];
  logic [7:0] expq [$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The trace is the DEPTH-long window of captured cycles starting PRE_TRIG before
  // the first trigger that arrives once at least PRE_TRIG samples have been taken.
  task automatic build_expect(output int ta);
    int          i;
    logic [15:0] first;
    ta = -1;
    for (int k = 0; k < MAXN; k++) if (ta < 0 && tg[k] && k >= PRE_TRIG) ta = k;
    expq.delete();
    first = 16'hFFFF;
    if (ta < 0) return;
    for (int e = 0; e < DEPTH; e++) begin
      i = ta - PRE_TRIG + e;
      if (dn[i] && i >= ta && first == 16'hFFFF) first = 16'(e);
    end
    if (HDR != 0) begin
      expq.push_back(8'hA5);
      expq.push_back(8'(NUM_CH));
      expq.push_back(first[15:8]);
      expq.push_back(first[7:0]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        i = ta - PRE_TRIG + e;
        expq.push_back((dn[i] && i >= ta) ? MARK : samp[i][c]);
      end
    end
  endtask

  task automatic do_trace(input int mode, input int early, input int tat, input int done_rel,
                          input int rnd, input int stall_max, input int long_at, input int rst_at);
    int ta, n, w, bad, seen, stall, base;
    base = cyc + 1;
    for (int i = 0; i < MAXN; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        samp[i][c] = (mode != 0) ? 8'(base + i + 64 * c) : 8'($urandom_range(255));
      tg[i] = (i == early) || (i == tat) || (rnd != 0 && i > tat && $urandom_range(3) == 0);
      dn[i] = (done_rel >= 0 && i == tat + done_rel) || (rnd != 0 && $urandom_range(5) == 0);
    end
    build_expect(ta);
    if (ta < 0) begin
      $display("FAIL stimulus: no acceptable trigger in plan");
      $fatal(1);
    end
    n = ta + DEPTH - PRE_TRIG;

    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    chk("busy_after_arm", 32'(bus.busy_o), 32'd1);

    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NUM_CH; c++) bus.sample_i[8*c +: 8] = samp[i][c];
      bus.trig_i = tg[i];
      bus.done_i = dn[i];
      tick();
    end
    bus.trig_i   = 1'b0;
    bus.done_i   = 1'b0;
    bus.sample_i = '0;

    for (int b = 0; b < TOTAL; b++) begin
      w = 0;
      while (bus.tx_dv_o !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      chk($sformatf("tx_dv_seen_b%0d", b), 32'(bus.tx_dv_o), 32'd1);
      if (bus.tx_dv_o !== 1'b1) return;
      chk($sformatf("byte_b%0d", b), 32'(bus.tx_byte_o), 32'(expq[b]));
      if (b == rst_at) begin
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("busy_after_rst", 32'(bus.busy_o), 32'd0);
        chk("dv_after_rst", 32'(bus.tx_dv_o), 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
          bus.tx_done_i = (k == 3);
          tick();
          if (bus.tx_dv_o !== 1'b0) seen++;
        end
        bus.tx_done_i = 1'b0;
        chk("no_dv_after_rst", 32'(seen), 32'd0);
        return;
      end
      stall = (b == long_at) ? 200 : int'($urandom_range(stall_max, 1));
      bad = 0;
      for (int k = 0; k < stall; k++) begin
        tick();
        if (bus.tx_dv_o !== 1'b0 || bus.tx_byte_o !== expq[b]) bad++;
      end
      chk($sformatf("hold_b%0d", b), 32'(bad), 32'd0);
      bus.tx_done_i = 1'b1;
      tick();
      bus.tx_done_i = 1'b0;
    end

    chk("trace_done_pulse", 32'(bus.trace_done_o), 32'd1);
    chk("busy_in_gap", 32'(bus.busy_o), 32'd1);
    bad = 0;
    for (int k = 1; k < GAP_CYCLES; k++) begin
      bus.arm_i     = (k < GAP_CYCLES - 2);
      bus.tx_done_i = (k == 2);
      tick();
      if (bus.busy_o !== 1'b1 || bus.trace_done_o !== 1'b0 || bus.tx_dv_o !== 1'b0) bad++;
    end
    bus.arm_i     = 1'b0;
    bus.tx_done_i = 1'b0;
    chk("gap_length", 32'(bad), 32'd0);
    tick();
    chk("gap_end_idle", 32'(bus.busy_o), 32'd0);
    tick();
    chk("arm_in_gap_ignored", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.arm_i     = 1'b0;
    bus.trig_i    = 1'b0;
    bus.done_i    = 1'b0;
    bus.tx_done_i = 1'b0;
    bus.sample_i  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_tx_dv", 32'(bus.tx_dv_o), 32'd0);
    chk("rst_tx_byte", 32'(bus.tx_byte_o), 32'd0);
    chk("rst_trace_done", 32'(bus.trace_done_o), 32'd0);
    bus.arm_i = 1'b1;
    tick();
    chk("arm_with_rst", 32'(bus.busy_o), 32'd0);
    rst       = 1'b0;
    bus.arm_i = 1'b0;
    tick();
    chk("idle_holds", 32'(bus.busy_o), 32'd0);

    // structured ramps, early trigger ignored, single done five after trigger
    do_trace(1, 2, 10, 5, 0, 3, -1, -1);
    // write pointer wrapped before the trigger, random done and stray triggers
    do_trace(0, -1, 37, -1, 1, 2, -1, -1);
    // earliest acceptable trigger, no done at all
    do_trace(0, 1, PRE_TRIG, -1, 0, 1, -1, -1);
    // done on the trigger cycle itself
    do_trace(0, -1, 6, 0, 1, 2, -1, -1);
    // long stall on byte 3, reset while byte 7 is outstanding
    do_trace(0, -1, 5, 3, 0, 2, 3, 7);
    // recovery after reset; first done at entry 9
    do_trace(1, -1, 8, 5, 0, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
- Parametrised on-chip sensor trace recorder and UART streamer for the cipher power-analysis setup.
- Continuously records NUM_CH sensor channels into a circular pre-trigger buffer once armed, and freezes a DEPTH-sample window around the cipher start strobe.
- Marks cipher-done cycles in the trace, then streams the trace byte-serially to the UART transmitter using its start/done handshake.
- Replaces the fixed single-channel, no-pretrigger capture loop in the top level.

Parameters:
- NUM_CH, 1: number of sensor channels, 1..8.
- DEPTH, 1024: samples per channel per trace; must be a power of 2, 16..4096.
- PRE_TRIG, 0: samples kept from before trig_i; 0..DEPTH-1.
- MARK_DONE, 8'hFF: byte stored in place of samples on cycles where done_i=1.
- GAP_CYCLES, 4096: idle cycles after readout before returning to IDLE (PDN recovery).

Ports:
- clk, in, 1: single clock for capture and readout.
- rst, in, 1: synchronous, active-high reset.
- sample_i, in, 8*NUM_CH: channel c occupies bits [8c+7:8c], for example a TDC popcount.
- arm_i, in, 1: start a trace. Sampled only in IDLE.
- trig_i, in, 1: cipher start strobe (Drdy).
- done_i, in, 1: cipher done (Dvld).
- tx_dv_o, out, 1: one-cycle UART send strobe.
- tx_byte_o, out, 8: byte to send. Held stable from tx_dv_o until tx_done_i.
- tx_done_i, in, 1: UART byte-complete pulse.
- busy_o, out, 1: high in every state except IDLE.
- trace_done_o, out, 1: one-cycle pulse on entry to GAP.

Behaviour:
- Reset: state=IDLE. tx_dv_o=0, tx_byte_o=0, busy_o=0, trace_done_o=0. All counters 0. Memory contents undefined and never read before being rewritten.
- IDLE: on arm_i=1, go to ARMED. Clear write pointer wp and prefill counter pf.
- ARMED: each cycle, write sample_i for all channels to mem[wp], then wp=(wp+1) mod DEPTH. pf saturates at PRE_TRIG.
  - trig_i is accepted only when pf==PRE_TRIG. Earlier strobes are ignored.
  - On acceptance: record start pointer sp=(wp-PRE_TRIG) mod DEPTH. The trigger-cycle sample is written at wp. Set the post-trigger count to DEPTH-PRE_TRIG-1. Go to CAPTURE.
- CAPTURE: each cycle, write one entry and decrement the post-trigger count.
  - If done_i=1, every channel stores MARK_DONE instead of its sample. This includes done_i on the trigger cycle itself.
  - When the count reaches 0 (last write), go to SEND.
  - The trace contains exactly DEPTH entries per channel. Entry 0 is the oldest pre-trigger sample, entry PRE_TRIG is the trigger cycle.
  - trig_i during CAPTURE is ignored.
- SEND: drive tx_byte_o=mem[channel][(sp+idx) mod DEPTH], pulse tx_dv_o for 1 cycle, go to SEND_WAIT.
  - Order: channel 0 idx 0..DEPTH-1, then channel 1, and so on.
  - Memory read latency of 1 cycle is absorbed inside SEND; tx_dv_o asserts only once the byte is valid.
- SEND_WAIT: hold tx_byte_o until tx_done_i=1.
  - If more bytes remain, advance idx/channel and go to SEND.
  - After the last byte (NUM_CH*DEPTH total), go to GAP and pulse trace_done_o.
  - tx_done_i in any other state is ignored.
- GAP: count GAP_CYCLES cycles, then go to IDLE. arm_i is ignored outside IDLE.
- Simultaneous events:
  - arm_i and rst together: rst wins.
  - trig_i and done_i on the same accepted cycle: trigger is taken and the entry holds MARK_DONE.
- rst in any state: return to IDLE within 1 cycle. A transfer in flight is abandoned; tx_dv_o is never reasserted for it.
- Widths: pointers are log2(DEPTH) bits and wrap naturally. Byte counter is log2(NUM_CH*DEPTH)+1 bits.

Optional Feature:
- Macro: TRACE_HDR_EN.
- Defined: before the first trace byte, send a 4-byte header using the same handshake:
  - byte 0: 8'hA5.
  - byte 1: NUM_CH.
  - bytes 2 and 3: index of the first MARK_DONE entry (16-bit, MSB first), or 16'hFFFF if none.
  - Total bytes per trace = 4 + NUM_CH*DEPTH.
- Not defined: no header, and no first-done index logic is generated.

Test Plan:
- Baseline: NUM_CH=1, DEPTH=16, PRE_TRIG=0, sample_i=cycle count mod 256. Arm, trig 3 cycles later, done_i once at the 5th post-trigger cycle. Expect 16 bytes: trigger-cycle value first, consecutive increments, FF at idx 5, then trace_done_o pulse.
- Pre-trigger: PRE_TRIG=4, DEPTH=16. Trig asserted at cycle 2 after arm (ignored), then at cycle 10. Expect byte 4 = value at cycle 10, bytes 0..3 = values at cycles 6..9.
- Pointer wrap: DEPTH=16, PRE_TRIG=4, trig 37 cycles after arm (wp wrapped). Expect 16 contiguous increasing values with no discontinuity.
- Multichannel: NUM_CH=3, ch0=k, ch1=k+64, ch2=k+128. Expect 48 bytes in channel-major order; tx_dv_o count=48.
- Handshake and reset: stall tx_done_i 200 cycles and check tx_byte_o is held. Assert rst during byte 7. Expect busy_o=0 next cycle, no further tx_dv_o, and a new arm_i accepted.
- TRACE_HDR_EN: NUM_CH=2, done at idx 9. Expect header A5 02 00 09 before the samples. With no done_i, header bytes 2–3 are FF FF.
